reservation_station_bank: RTL

DEPTH-entry reservation station holding ALU instructions until both operands are available. It replaces the single-entry reservation_station in front of alu_functional_unit. Entries snoop the CDB for missing operands. Each cycle the oldest ready entry is presented to the FU with a ready/accept handshake. The bank adds multi-entry allocation, oldest-first selection, issue-cycle CDB bypass, occupancy reporting and flush.

---
 rtl/rs_pkg.sv | 48 ++++
 rtl/rs_entry.sv | 116 +++++++++++
 rtl/reservation_station_bank.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the reservation station bank:
//   - default widths for the bank and the ALU functional unit behind it
//   - ALU op encodings, shared with alu_functional_unit
//   - rs_entry_t, the layout of one entry in the default configuration
//   - occ_width(), the width needed to count 0..DEPTH busy entries
// No ports (package).
// -----------------------------------------------------------------------------
package rs_pkg;

   localparam int RS_XLEN         = 32;
   localparam int RS_TAG_WIDTH    = 32;
   localparam int RS_DEPTH        = 4;
   localparam int RS_ALU_OP_WIDTH = 3;

   // A counter of 0..depth needs clog2(depth+1) bits, not clog2(depth).
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int RS_OCC_WIDTH = occ_width(RS_DEPTH);

   typedef enum logic [RS_ALU_OP_WIDTH-1:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic                       busy;
      logic [RS_TAG_WIDTH-1:0]    q1;
      logic                       q1_valid;
      logic [RS_XLEN-1:0]         v1;
      logic [RS_TAG_WIDTH-1:0]    q2;
      logic                       q2_valid;
      logic [RS_XLEN-1:0]         v2;
      logic [RS_ALU_OP_WIDTH-1:0] alu_op;
      logic                       alu_sign;
      logic [RS_TAG_WIDTH-1:0]    rob_tag;
   } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// -----------------------------------------------------------------------------
// rs_entry
// One reservation-station entry: holds an ALU instruction, snoops the CDB for
// its missing operands, and flags itself ready once both are present.
// Ports:
//   clk, reset (async, active-low), flush (sync clear of busy)
//   load       - write the issue fields into this (free) entry this edge
//   dispatch   - the FU accepted this entry; free it this edge
//   q*_in, q*_valid_in, v*_in, alu_op_in, alu_sign_in,
//   reorder_buffer_tag_in - issue fields
//   cdb_active, cdb_tag, cdb_data - common data bus
//   busy, ready               - entry status (registered state)
//   v1, v2, alu_op, alu_sign, reorder_buffer_tag - stored payload
// -----------------------------------------------------------------------------
module rs_entry
   import rs_pkg::*;
#(
   parameter int XLEN         = RS_XLEN,
   parameter int TAG_WIDTH    = RS_TAG_WIDTH,
   parameter int ALU_OP_WIDTH = RS_ALU_OP_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    load,
   input  logic                    dispatch,
   input  logic [TAG_WIDTH-1:0]    q1_in,
   input  logic                    q1_valid_in,
   input  logic [XLEN-1:0]         v1_in,
   input  logic [TAG_WIDTH-1:0]    q2_in,
   input  logic                    q2_valid_in,
   input  logic [XLEN-1:0]         v2_in,
   input  logic [ALU_OP_WIDTH-1:0] alu_op_in,
   input  logic                    alu_sign_in,
   input  logic [TAG_WIDTH-1:0]    reorder_buffer_tag_in,
   input  logic                    cdb_active,
   input  logic [TAG_WIDTH-1:0]    cdb_tag,
   input  logic [XLEN-1:0]         cdb_data,
   output logic                    busy,
   output logic                    ready,
   output logic [XLEN-1:0]         v1,
   output logic [XLEN-1:0]         v2,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic                    alu_sign,
   output logic [TAG_WIDTH-1:0]    reorder_buffer_tag
);

   logic [TAG_WIDTH-1:0] q1;
   logic [TAG_WIDTH-1:0] q2;
   logic                 q1_valid;
   logic                 q2_valid;

   // Issue-time bypass: the producer is broadcasting in the very cycle we
   // issue, so take the value now instead of waiting for a repeat broadcast.
   logic bypass1;
   logic bypass2;
   assign bypass1 = q1_valid_in & cdb_active & (cdb_tag == q1_in);
   assign bypass2 = q2_valid_in & cdb_active & (cdb_tag == q2_in);

   // Wakeup of an already-resident entry.
   logic wake1;
   logic wake2;
   assign wake1 = busy & q1_valid & cdb_active & (cdb_tag == q1);
   assign wake2 = busy & q2_valid & cdb_active & (cdb_tag == q2);

   assign ready = busy & ~q1_valid & ~q2_valid;

   // NOTE: state is updated with <= so every entry samples the pre-edge
   // values of busy/q*_valid, independent of evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the payload is reset along with the control bits; it is only
         // DEPTH words and keeps X out of the select mux after reset.
         busy               <= 1'b0;
         q1                 <= '0;
         q1_valid           <= 1'b0;
         v1                 <= '0;
         q2                 <= '0;
         q2_valid           <= 1'b0;
         v2                 <= '0;
         alu_op             <= '0;
         alu_sign           <= 1'b0;
         reorder_buffer_tag <= '0;
      end else if (flush) begin
         busy     <= 1'b0;
         q1_valid <= 1'b0;
         q2_valid <= 1'b0;
      end else if (load) begin
         busy               <= 1'b1;
         q1                 <= q1_in;
         q2                 <= q2_in;
         q1_valid           <= q1_valid_in & ~bypass1;
         q2_valid           <= q2_valid_in & ~bypass2;
         v1                 <= bypass1 ? cdb_data : v1_in;
         v2                 <= bypass2 ? cdb_data : v2_in;
         alu_op             <= alu_op_in;
         alu_sign           <= alu_sign_in;
         reorder_buffer_tag <= reorder_buffer_tag_in;
      end else begin
         // load only targets free entries and dispatch only ready ones,
         // so the two branches never compete for the same entry.
         if (dispatch) begin
            busy <= 1'b0;
         end
         if (wake1) begin
            v1       <= cdb_data;
            q1_valid <= 1'b0;
         end
         if (wake2) begin
            v2       <= cdb_data;
            q2_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/reservation_station_bank.sv
// -----------------------------------------------------------------------------
// reservation_station_bank
// DEPTH-entry reservation station in front of alu_functional_unit. Allocates
// the lowest free entry on issue, wakes entries from the CDB, and presents the
// oldest ready entry to the FU with a ready/accept handshake.
// Ports:
//   clk, reset (async, active-low), flush (sync clear of all entries)
//   enable + q*/q*_valid/v*/alu_op/alu_sign/reorder_buffer_tag _in - issue
//   full, occupancy           - registered-state status
//   cdb_active, cdb_tag, cdb_data - common data bus
//   ready_to_execute, v*_out, alu_op_out, alu_sign_out,
//   reorder_buffer_tag_out    - selected entry (zero when none ready)
//   dispatched_in             - FU accepted the presented entry
// -----------------------------------------------------------------------------
module reservation_station_bank
   import rs_pkg::*;
#(
   parameter int XLEN         = RS_XLEN,
   parameter int TAG_WIDTH    = RS_TAG_WIDTH,
   parameter int DEPTH        = RS_DEPTH,
   parameter int ALU_OP_WIDTH = RS_ALU_OP_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enable,
   input  logic [TAG_WIDTH-1:0]       q1_in,
   input  logic [TAG_WIDTH-1:0]       q2_in,
   input  logic                       q1_valid_in,
   input  logic                       q2_valid_in,
   input  logic [XLEN-1:0]            v1_in,
   input  logic [XLEN-1:0]            v2_in,
   input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
   input  logic                       alu_sign_in,
   input  logic [TAG_WIDTH-1:0]       reorder_buffer_tag_in,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   input  logic                       cdb_active,
   input  logic [TAG_WIDTH-1:0]       cdb_tag,
   input  logic [XLEN-1:0]            cdb_data,
   output logic                       ready_to_execute,
   output logic [XLEN-1:0]            v1_out,
   output logic [XLEN-1:0]            v2_out,
   output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
   output logic                       alu_sign_out,
   output logic [TAG_WIDTH-1:0]       reorder_buffer_tag_out,
   input  logic                       dispatched_in
);

   localparam int OCC_WIDTH = occ_width(DEPTH);

   logic [DEPTH-1:0]        busy;
   logic [DEPTH-1:0]        ready;
   logic [DEPTH-1:0]        alloc;
   logic [DEPTH-1:0]        grant;
   logic [DEPTH-1:0]        load;
   logic [DEPTH-1:0]        dispatch;
   logic                    issue;
   logic [OCC_WIDTH-1:0]    occ_count;

   logic [XLEN-1:0]         e_v1     [DEPTH];
   logic [XLEN-1:0]         e_v2     [DEPTH];
   logic [ALU_OP_WIDTH-1:0] e_op     [DEPTH];
   logic                    e_sign   [DEPTH];
   logic [TAG_WIDTH-1:0]    e_tag    [DEPTH];

   // older[i][j] = 1 means entry i was issued before entry j.
   logic [DEPTH-1:0]        older     [DEPTH];
   logic [DEPTH-1:0]        older_col [DEPTH];

   // full comes from registered busy bits, so a slot freed by a dispatch in
   // this cycle only becomes allocatable on the next one.
   assign issue    = enable & ~full & ~flush;
   assign load     = alloc & {DEPTH{issue}};
   assign dispatch = grant & {DEPTH{dispatched_in}};

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      rs_entry #(
         .XLEN         (XLEN),
         .TAG_WIDTH    (TAG_WIDTH),
         .ALU_OP_WIDTH (ALU_OP_WIDTH)
      ) u_entry (
         .clk                   (clk),
         .reset                 (reset),
         .flush                 (flush),
         .load                  (load[i]),
         .dispatch              (dispatch[i]),
         .q1_in                 (q1_in),
         .q1_valid_in           (q1_valid_in),
         .v1_in                 (v1_in),
         .q2_in                 (q2_in),
         .q2_valid_in           (q2_valid_in),
         .v2_in                 (v2_in),
         .alu_op_in             (alu_op_in),
         .alu_sign_in           (alu_sign_in),
         .reorder_buffer_tag_in (reorder_buffer_tag_in),
         .cdb_active            (cdb_active),
         .cdb_tag               (cdb_tag),
         .cdb_data              (cdb_data),
         .busy                  (busy[i]),
         .ready                 (ready[i]),
         .v1                    (e_v1[i]),
         .v2                    (e_v2[i]),
         .alu_op                (e_op[i]),
         .alu_sign              (e_sign[i]),
         .reorder_buffer_tag    (e_tag[i])
      );
   end

   // Occupancy is the popcount of the busy bits.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch
      // can be inferred on any path through the loop.
      occ_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_count = occ_count + OCC_WIDTH'(busy[i]);
      end
   end

   assign occupancy = occ_count;
   assign full      = (occ_count == OCC_WIDTH'(DEPTH));

   // Lowest-index free entry: scanning downward lets the lowest one win.
   always_comb begin
      alloc = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            alloc    = '0;
            alloc[i] = 1'b1;
         end
      end
   end

   // Entry i is granted when it is ready and no ready entry is older.
   always_comb begin
      grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         older_col[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            older_col[i][j] = older[j][i];
         end
         grant[i] = ready[i] & ~|(ready & older_col[i]);
      end
   end

   // AND-OR mux over a one-hot grant; all outputs fall to zero with no grant.
   always_comb begin
      ready_to_execute       = |grant;
      v1_out                 = '0;
      v2_out                 = '0;
      alu_op_out             = '0;
      alu_sign_out           = 1'b0;
      reorder_buffer_tag_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v1_out                 = v1_out     | ({XLEN{grant[i]}} & e_v1[i]);
         v2_out                 = v2_out     | ({XLEN{grant[i]}} & e_v2[i]);
         alu_op_out             = alu_op_out | ({ALU_OP_WIDTH{grant[i]}} & e_op[i]);
         alu_sign_out           = alu_sign_out | (grant[i] & e_sign[i]);
         reorder_buffer_tag_out = reorder_buffer_tag_out
                                | ({TAG_WIDTH{grant[i]}} & e_tag[i]);
      end
   end

   // Age matrix: a newly issued entry is younger than every busy entry.
   // Its own row is cleared; stale bits of freed entries are overwritten
   // when those entries are reissued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            older[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            older[i] <= '0;
         end
      end else if (issue) begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (alloc[i]) begin
                  older[i][j] <= 1'b0;
               end else if (alloc[j]) begin
                  older[i][j] <= busy[i];
               end
            end
         end
      end
   end

endmodule
